// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780-style 8-bit init, then event-driven repaint of a COLS x LINES character buffer
// with a timed lcd_e strobe inside fixed-length byte slots.
module lcd_text_ctrl #(
    parameter int COLS      = 16,
    parameter int LINES     = 2,
    parameter int PWRUP_CYC = 20000,
    parameter int SLOT_CYC  = 40,
    parameter int E_CYC     = 12,
    parameter int CLR_CYC   = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_line,
    input  logic [5:0] wr_col,
    input  logic [7:0] wr_char,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);
    localparam int N    = LINES * COLS;
    localparam int IW   = N > 1 ? $clog2(N) : 1;
    localparam int SW   = $clog2(SLOT_CYC);
    localparam int WMAX = PWRUP_CYC > CLR_CYC ? PWRUP_CYC : CLR_CYC;
    localparam int CW   = $clog2(WMAX + 1);

    typedef enum logic [3:0] {PWRUP, FSET, DISP, ENTRY, CLEAR, CLRW, IDLE, ADDR, CHAR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] s_q, s_d;
    logic          line_q, line_d;
    logic [5:0]    col_q, col_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          dirty_q, dirty_d;
    logic [7:0]    buf_q [N];
    logic [7:0]    buf_d [N];
    logic          slot, slot_end, wr_ok;
    logic [IW-1:0] wr_idx, rd_idx;

    assign slot     = state_q inside {FSET, DISP, ENTRY, CLEAR, ADDR, CHAR};
    assign slot_end = s_q == SW'(SLOT_CYC - 1);
    assign wr_ok    = wr_en && int'(wr_col) < COLS && int'(wr_line) < LINES;
    assign wr_idx   = IW'(int'(wr_line) * COLS + int'(wr_col));
    // Address of the character loaded at the next slot boundary: column 0 from ADDR, col+1 from CHAR
    assign rd_idx   = IW'(int'(line_q) * COLS + (state_q == CHAR ? int'(col_q) + 1 : 0));

    assign lcd_e    = slot && s_q != '0 && s_q <= SW'(E_CYC);
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_data = data_q;
    assign busy     = state_q != IDLE;

    always_comb begin
        buf_d = buf_q;
        if (wr_ok) buf_d[wr_idx] = wr_char;
        dirty_d = wr_ok || (dirty_q && state_q != IDLE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = slot && !slot_end ? s_q + 1'b1 : '0;
        line_d  = line_q;
        col_d   = col_q;
        rs_d    = rs_q;
        data_d  = data_q;
        case (state_q)
            PWRUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(PWRUP_CYC - 1)) begin
                    state_d = FSET;
                    cnt_d   = '0;
                    rs_d    = 1'b0;
                    data_d  = LINES == 2 ? 8'h38 : 8'h30;
                end
            end
            FSET:  if (slot_end) begin state_d = DISP;  data_d = 8'h0C; end
            DISP:  if (slot_end) begin state_d = ENTRY; data_d = 8'h06; end
            ENTRY: if (slot_end) begin state_d = CLEAR; data_d = 8'h01; end
            CLEAR: if (slot_end) state_d = CLRW;
            CLRW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(CLR_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: if (dirty_q) begin
                state_d = ADDR;
                line_d  = 1'b0;
                rs_d    = 1'b0;
                data_d  = 8'h80;
            end
            ADDR: if (slot_end) begin
                state_d = CHAR;
                col_d   = '0;
                rs_d    = 1'b1;
                data_d  = buf_q[rd_idx];
            end
            CHAR: if (slot_end) begin
                if (col_q != 6'(COLS - 1)) begin
                    col_d  = col_q + 1'b1;
                    data_d = buf_q[rd_idx];
                end else if (LINES == 2 && !line_q) begin
                    state_d = ADDR;
                    line_d  = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = 8'hC0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            s_q     <= '0;
            line_q  <= 1'b0;
            col_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            dirty_q <= 1'b1;
            for (int i = 0; i < N; i++) buf_q[i] <= 8'h20;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            line_q  <= line_d;
            col_q   <= col_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            dirty_q <= dirty_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: two controllers (16x2 and 8x1) checked against a character-buffer model;
// a bus monitor records each strobed byte, its strobe width and the cycle busy falls.
module tb_lcd_text_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, wr_en0, wr_en1, wr_line0, wr_line1;
    logic [5:0] wr_col0, wr_col1;
    logic [7:0] wr_char0, wr_char1, d0, d1;
    logic       busy0, busy1, e0, e1, rs0, rs1, rw0, rw1;

    lcd_text_ctrl #(.COLS(16), .LINES(2), .PWRUP_CYC(100), .SLOT_CYC(8), .E_CYC(3), .CLR_CYC(20)) u0 (
        .clk(clk), .reset(rst0), .wr_en(wr_en0), .wr_line(wr_line0), .wr_col(wr_col0), .wr_char(wr_char0),
        .busy(busy0), .lcd_e(e0), .lcd_rs(rs0), .lcd_rw(rw0), .lcd_data(d0));
    lcd_text_ctrl #(.COLS(8), .LINES(1), .PWRUP_CYC(100), .SLOT_CYC(8), .E_CYC(3), .CLR_CYC(20)) u1 (
        .clk(clk), .reset(rst1), .wr_en(wr_en1), .wr_line(wr_line1), .wr_col(wr_col1), .wr_char(wr_char1),
        .busy(busy1), .lcd_e(e1), .lcd_rs(rs1), .lcd_rw(rw1), .lcd_data(d1));

    int errors = 0, checks = 0, cyc = 0;
    logic [8:0] bq0[$], bq1[$], exp_q[$];
    int rq0[$], rq1[$], wq0[$], wq1[$], iq0[$], iq1[$];
    logic [7:0] m0 [2][40];
    logic [7:0] m1 [2][40];
    logic pe0 = 1'b0, pe1 = 1'b0, pb0 = 1'b1, pb1 = 1'b1;
    logic [8:0] hold0, hold1;
    int w0 = 0, w1 = 0, viol0 = 0, viol1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pe0 <= e0;
        pb0 <= busy0;
        if (e0 && !pe0) begin bq0.push_back({rs0, d0}); rq0.push_back(cyc); hold0 <= {rs0, d0}; w0 <= 1; end
        else if (e0) begin w0 <= w0 + 1; if ({rs0, d0} !== hold0) viol0 <= viol0 + 1; end
        if (!e0 && pe0) wq0.push_back(w0);
        if (!busy0 && pb0) iq0.push_back(cyc);
    end

    always @(negedge clk) begin
        pe1 <= e1;
        pb1 <= busy1;
        if (e1 && !pe1) begin bq1.push_back({rs1, d1}); rq1.push_back(cyc); hold1 <= {rs1, d1}; w1 <= 1; end
        else if (e1) begin w1 <= w1 + 1; if ({rs1, d1} !== hold1) viol1 <= viol1 + 1; end
        if (!e1 && pe1) wq1.push_back(w1);
        if (!busy1 && pb1) iq1.push_back(cyc);
    end

    function automatic void add_init(input logic [7:0] fset);
        exp_q.push_back({1'b0, fset});
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endfunction

    function automatic void add_refresh(input logic [7:0] m [2][40], input int lines, input int cols);
        for (int l = 0; l < lines; l++) begin
            exp_q.push_back({1'b0, l == 0 ? 8'h80 : 8'hC0});
            for (int c = 0; c < cols; c++) exp_q.push_back({1'b1, m[l][c]});
        end
    endfunction

    function automatic int first_diff(input logic [8:0] a[$], input logic [8:0] b[$]);
        int n = a.size() < b.size() ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return a.size() == b.size() ? -1 : n;
    endfunction

    function automatic void clear(input int dut);
        if (dut == 0) begin bq0.delete(); rq0.delete(); wq0.delete(); iq0.delete(); end
        else begin bq1.delete(); rq1.delete(); wq1.delete(); iq1.delete(); end
        exp_q.delete();
    endfunction

    task automatic wr(input int dut, input int line, input int col, input logic [7:0] ch);
        @(negedge clk);
        if (dut == 0) begin
            wr_en0 = 1'b1; wr_line0 = line[0]; wr_col0 = col[5:0]; wr_char0 = ch;
            if (line < 2 && col < 16) m0[line][col] = ch;
        end else begin
            wr_en1 = 1'b1; wr_line1 = line[0]; wr_col1 = col[5:0]; wr_char1 = ch;
            if (line < 1 && col < 8) m1[line][col] = ch;
        end
    endtask

    task automatic wr_off();
        @(negedge clk);
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
    endtask

    task automatic wait_idle(input int dut, input int n);
        int t = 0;
        while ((dut == 0 ? iq0.size() : iq1.size()) < n && t < 3000) begin @(negedge clk); t++; end
        if ((dut == 0 ? iq0.size() : iq1.size()) < n) begin
            checks++; errors++;
            $display("FAIL wait_idle dut%0d: idle events %0d, required %0d", dut, dut == 0 ? iq0.size() : iq1.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 2;
        if ({busy0, e0, rs0, rw0, d0} !== 12'h800) begin
            errors++; $display("FAIL reset0: busy,e,rs,rw,data=%h required 800", {busy0, e0, rs0, rw0, d0});
        end
        if ({busy1, e1, rs1, rw1, d1} !== 12'h800) begin
            errors++; $display("FAIL reset1: busy,e,rs,rw,data=%h required 800", {busy1, e1, rs1, rw1, d1});
        end
    endtask

    task automatic test_init(output int c0);
        int eh = 0, bad = 0, k;
        @(negedge clk);
        c0 = cyc;
        rst0 = 1'b1;
        repeat (100) begin @(negedge clk); if (e0) eh++; end
        checks++;
        if (eh != 0) begin errors++; $display("FAIL pwrup_quiet: lcd_e high %0d cycles, required 0", eh); end
        wait_idle(0, 1);
        checks++;
        if (iq0.size() < 1 || iq0[0] - c0 != 152) begin
            errors++; $display("FAIL init_latency: %0d, required 152", iq0.size() < 1 ? -1 : iq0[0] - c0);
        end
        clear_exp_init(8'h38);
        k = first_diff(bq0, exp_q);
        checks++;
        if (k != -1) begin
            errors++; $display("FAIL init_bytes: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq0.size() ? bq0[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq0.size(), exp_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i >= rq0.size() || rq0[i] - c0 != 101 + 8 * i) bad++;
            if (i >= wq0.size() || wq0[i] != 3) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL init_strobe: %0d bad rise times/widths, required 0", bad); end
    endtask

    function automatic void clear_exp_init(input logic [7:0] fset);
        exp_q.delete();
        add_init(fset);
    endfunction

    task automatic test_initial_refresh();
        int k, bad = 0;
        wait_idle(0, 2);
        clear_exp_init(8'h38);
        add_refresh(m0, 2, 16);
        k = first_diff(bq0, exp_q);
        checks++;
        if (k != -1) begin
            errors++; $display("FAIL first_refresh: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq0.size() ? bq0[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq0.size(), exp_q.size());
        end
        checks++;
        if (iq0.size() < 2 || iq0[1] - iq0[0] != 273) begin
            errors++; $display("FAIL refresh_len: %0d, required 273", iq0.size() < 2 ? -1 : iq0[1] - iq0[0]);
        end
        checks++;
        if (rq0.size() < 5 || rq0[4] - rq0[3] != 29) begin
            errors++; $display("FAIL clear_wait: %0d, required 29", rq0.size() < 5 ? -1 : rq0[4] - rq0[3]);
        end
        foreach (wq0[i]) if (wq0[i] != 3) bad++;
        checks++;
        if (bad != 0 || viol0 != 0) begin
            errors++; $display("FAIL strobe_shape: bad widths %0d unstable %0d, required 0/0", bad, viol0);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy: %b, required 0", busy0); end
    endtask

    task automatic test_idle_write();
        int k, line, col;
        for (int r = 0; r < 4; r++) begin
            clear(0);
            line = r == 0 ? 1 : int'($urandom_range(0, 1));
            col  = r == 0 ? 3 : int'($urandom_range(0, 15));
            wr(0, line, col, r == 0 ? 8'h41 : 8'($urandom_range(8'h21, 8'h7E)));
            wr_off();
            add_refresh(m0, 2, 16);
            wait_idle(0, 1);
            repeat (40) @(negedge clk);
            k = first_diff(bq0, exp_q);
            checks += 2;
            if (k != -1) begin
                errors++; $display("FAIL idle_write[%0d]: idx %0d got %h exp %h (len %0d/%0d)", r, k,
                    k < bq0.size() ? bq0[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq0.size(), exp_q.size());
            end
            if (iq0.size() != 1 || busy0 !== 1'b0) begin
                errors++; $display("FAIL single_refresh[%0d]: refreshes %0d busy %b, required 1/0", r, iq0.size(), busy0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        clear(0);
        wr(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom_range(8'h21, 8'h7E)));
        wr(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom_range(8'h21, 8'h7E)));
        wr_off();
        add_refresh(m0, 2, 16);
        add_refresh(m0, 2, 16);
        wait_idle(0, 2);
        repeat (40) @(negedge clk);
        k = first_diff(bq0, exp_q);
        checks += 2;
        if (k != -1) begin
            errors++; $display("FAIL back_to_back: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq0.size() ? bq0[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq0.size(), exp_q.size());
        end
        if (iq0.size() != 2) begin errors++; $display("FAIL set_wins: refreshes %0d, required 2", iq0.size()); end
    endtask

    task automatic test_write_during_refresh();
        int k, t = 0;
        clear(0);
        wr(0, 1, 10, 8'($urandom_range(8'h21, 8'h7E)));
        wr_off();
        add_refresh(m0, 2, 16);
        while (bq0.size() < 7 && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (bq0.size() < 7) begin errors++; $display("FAIL reach_col5: bytes %0d, required 7", bq0.size()); end
        wr(0, 0, 2, 8'h42);
        wr_off();
        add_refresh(m0, 2, 16);
        wait_idle(0, 2);
        k = first_diff(bq0, exp_q);
        checks += 2;
        if (k != -1) begin
            errors++; $display("FAIL mid_refresh_write: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq0.size() ? bq0[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq0.size(), exp_q.size());
        end
        if (iq0.size() < 2 || iq0[1] - iq0[0] != 273 || viol0 != 0) begin
            errors++; $display("FAIL rerefresh_gap: %0d unstable %0d, required 273/0",
                iq0.size() < 2 ? -1 : iq0[1] - iq0[0], viol0);
        end
    endtask

    task automatic test_out_of_range();
        int k;
        clear(0);
        for (int i = 0; i < 4; i++) wr(0, int'($urandom_range(0, 1)), int'($urandom_range(16, 63)), 8'($urandom));
        wr_off();
        repeat (60) @(negedge clk);
        checks++;
        if (bq0.size() != 0 || iq0.size() != 0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL oor_no_refresh: bytes %0d refreshes %0d busy %b, required 0/0/0", bq0.size(), iq0.size(), busy0);
        end
        wr(0, 0, 15, 8'($urandom_range(8'h21, 8'h7E)));
        wr_off();
        add_refresh(m0, 2, 16);
        wait_idle(0, 1);
        k = first_diff(bq0, exp_q);
        checks++;
        if (k != -1) begin
            errors++; $display("FAIL oor_buffer: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq0.size() ? bq0[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq0.size(), exp_q.size());
        end
    endtask

    task automatic test_lines1();
        int k, c1, t = 0;
        logic pre_e;
        @(negedge clk);
        c1 = cyc;
        rst1 = 1'b1;
        wait_idle(1, 2);
        clear_exp_init(8'h30);
        add_refresh(m1, 1, 8);
        k = first_diff(bq1, exp_q);
        checks += 2;
        if (k != -1) begin
            errors++; $display("FAIL l1_init_refresh: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq1.size() ? bq1[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq1.size(), exp_q.size());
        end
        if (iq1.size() < 2 || iq1[0] - c1 != 152 || iq1[1] - iq1[0] != 73) begin
            errors++; $display("FAIL l1_timing: init %0d refresh %0d, required 152/73",
                iq1.size() < 1 ? -1 : iq1[0] - c1, iq1.size() < 2 ? -1 : iq1[1] - iq1[0]);
        end
        clear(1);
        wr(1, 1, int'($urandom_range(0, 7)), 8'h55);
        wr(1, 0, int'($urandom_range(8, 63)), 8'h66);
        wr_off();
        repeat (60) @(negedge clk);
        checks++;
        if (bq1.size() != 0 || iq1.size() != 0) begin
            errors++; $display("FAIL l1_oor: bytes %0d refreshes %0d, required 0/0", bq1.size(), iq1.size());
        end
        wr(1, 0, int'($urandom_range(0, 7)), 8'($urandom_range(8'h21, 8'h7E)));
        wr_off();
        add_refresh(m1, 1, 8);
        wait_idle(1, 1);
        k = first_diff(bq1, exp_q);
        checks++;
        if (k != -1) begin
            errors++; $display("FAIL l1_write: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq1.size() ? bq1[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq1.size(), exp_q.size());
        end
        clear(1);
        wr(1, 0, 0, 8'h7A);
        wr_off();
        while (bq1.size() < 3 && t < 2000) begin @(negedge clk); t++; end
        #2;
        pre_e = e1;
        rst1 = 1'b0;
        #1;
        checks++;
        if ({pre_e, e1, d1, rs1, busy1} !== 12'b1_0_00000000_0_1) begin
            errors++; $display("FAIL async_reset: pre_e,e,data,rs,busy=%b, required 100000000001", {pre_e, e1, d1, rs1, busy1});
        end
        foreach (m1[l, c]) m1[l][c] = 8'h20;
        @(negedge clk);
        rst1 = 1'b1;
        clear(1);
        wait_idle(1, 2);
        clear_exp_init(8'h30);
        add_refresh(m1, 1, 8);
        k = first_diff(bq1, exp_q);
        checks++;
        if (k != -1) begin
            errors++; $display("FAIL buffer_lost: idx %0d got %h exp %h (len %0d/%0d)", k,
                k < bq1.size() ? bq1[k] : 9'h1ff, k < exp_q.size() ? exp_q[k] : 9'h1ff, bq1.size(), exp_q.size());
        end
    endtask

    initial begin
        int c0;
        rst0 = 1'b0; rst1 = 1'b0;
        wr_en0 = 1'b0; wr_line0 = 1'b0; wr_col0 = '0; wr_char0 = '0;
        wr_en1 = 1'b0; wr_line1 = 1'b0; wr_col1 = '0; wr_char1 = '0;
        foreach (m0[l, c]) m0[l][c] = 8'h20;
        foreach (m1[l, c]) m1[l][c] = 8'h20;
        test_reset();
        test_init(c0);
        test_initial_refresh();
        clear(0);
        test_idle_write();
        test_back_to_back();
        test_write_during_refresh();
        test_out_of_range();
        test_lines1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcd_text_ctrl.md
# lcd_text_ctrl

Parametrised character-LCD controller for the taximeter display path, a successor to the fixed-text LCD driver. Runs HD44780-style 8-bit initialisation, then repaints the display from an internal COLS×LINES character buffer that other taximeter logic writes one character at a time. It generates a real, timed lcd_e strobe instead of forwarding clk. Refresh is event-driven: it runs only when the buffer has been written.

## Interface
- COLS, 16: characters per line, 1..40
- LINES, 2: display lines, 1 or 2
- PWRUP_CYC, 20000: clk cycles of power-up wait before the first command
- SLOT_CYC, 40: clk cycles per LCD byte transfer, ≥ E_CYC+2
- E_CYC, 12: clk cycles lcd_e is high within a slot, ≥1
- CLR_CYC, 2000: extra wait cycles after the clear command

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  buffer write strobe, one character per cycle
- wr_line  in  1  target line; must be 0 when LINES=1
- wr_col  in  6  target column
- wr_char  in  8  ASCII code
- busy  out  1  high whenever the FSM is not in IDLE
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied low (write-only)
- lcd_data  out  8  LCD data bus

## Operation
- Reset (reset=0) values:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, busy=1.
  - Every buffer entry = 0x20.
  - FSM in PWRUP.
  - dirty=1, so the first refresh after init draws the blank buffer.
- Buffer write:
  - Accepted on any cycle, in any state, when wr_en=1, wr_col<COLS and wr_line<LINES.
  - An accepted write stores wr_char and sets dirty.
  - An out-of-range write is dropped: buffer and dirty are unchanged.
- States and transitions:
  - PWRUP: wait PWRUP_CYC cycles, then FSET.
  - FSET: send 0x38 if LINES=2, else 0x30.
  - DISP: send 0x0C.
  - ENTRY: send 0x06.
  - CLEAR: send 0x01, then wait CLR_CYC cycles.
  - IDLE: when dirty=1, clear dirty and go to ADDR with line=0.
  - ADDR: send 0x80 for line 0 or 0xC0 for line 1, then CHAR with col=0.
  - CHAR: send buffer[line][col] with rs=1, one slot per column.
  - After col COLS-1: go to ADDR line 1 if LINES=2 and line=0; otherwise go to IDLE.
- Commands are sent with rs=0. Characters are sent with rs=1.
- The character byte is sampled from the buffer at slot cycle 0. A write to that location later in the same slot is not shown in the current pass. It sets dirty, so another full refresh follows.
- Simultaneous write and dirty-clear on the IDLE→ADDR cycle: the set wins, so dirty stays 1.
- An asynchronous reset assertion at any point, including mid-slot or mid-refresh, immediately forces all reset values. The buffer contents are lost.

## Timing
- Slot counter s runs 0..SLOT_CYC-1 for every byte transfer:
  - s=0: lcd_rs and lcd_data take new values; lcd_e=0.
  - s=1..E_CYC: lcd_e=1.
  - s=E_CYC+1..SLOT_CYC-1: lcd_e=0.
  - lcd_rs and lcd_data are stable for the whole slot. lcd_e falls at least SLOT_CYC-E_CYC-1 cycles before the next change.
- Outside slots (PWRUP, the CLR_CYC wait, IDLE): lcd_e=0, and lcd_rs/lcd_data hold their last values.
- Init latency from reset release to IDLE is exactly PWRUP_CYC + 4·SLOT_CYC + CLR_CYC cycles.
- Refresh latency:
  - The first ADDR slot starts 1 cycle after IDLE sees dirty=1.
  - A full refresh lasts LINES·(COLS+1)·SLOT_CYC cycles.
  - busy falls on the cycle IDLE is re-entered.
- No slot is ever shortened. The counters wrap only via explicit terminal compares.

## Test plan
Common parameters: PWRUP_CYC=100, SLOT_CYC=8, E_CYC=3, CLR_CYC=20, COLS=16, LINES=2.

1. Reset/init: release reset at t0. Required:
   - lcd_e=0 for 100 cycles.
   - Command bytes 0x38, 0x0C, 0x06, 0x01 with rs=0, each with a 3-cycle lcd_e pulse starting at slot cycle 1.
   - 20 idle cycles after 0x01.
2. Initial refresh: with no writes, the data sequence is:
   - 0x80(rs=0), then 16×0x20(rs=1)
   - 0xC0(rs=0), then 16×0x20(rs=1)
   - busy goes low after 34 slots.
3. Idle write: write 0x41 to line 1, col 3 while idle. Required: exactly one refresh follows, and the 4th character after 0xC0 is 0x41; all other characters are 0x20.
4. Write during refresh: during line-0 col 5, write 0x42 to line 0, col 2. Required: the current pass still shows 0x20 at col 2; a second refresh follows immediately with 0x42 at col 2.
5. Out-of-range write: write col 16 (and line 1 with LINES=1). Required: dirty not set; no refresh; buffer unchanged.
6. LINES=1, COLS=8: FSET byte is 0x30; a refresh is 0x80 + 8 characters with no 0xC0. Assert reset mid-CHAR slot: lcd_e falls to 0 and lcd_data goes to 0x00 within the same cycle.
